branch_predictor: RTL

- Dynamic branch direction predictor for the RV32IM core; consumes the resolved outcome (o_take) of branch_unit and predicts direction for the next fetch.
- Table of 2^IDX_BITS 2-bit saturating counters, indexed by PC word bits. Prediction is combinational at fetch; training is sequential at execute.
- Keeps branch and mispredict counters for lab performance measurement.

---
 rtl/branch_predictor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// branch_predictor: bimodal branch direction predictor.
// A table of 2^IDX_BITS two-bit saturating counters is indexed by PC word
// bits. Prediction is combinational at fetch; training happens at the clock
// edge when a resolved conditional branch is presented. Branch and
// mispredict statistics are kept in saturating counters.
//
// Optional feature macro: BRANCH_PREDICTOR_GSHARE_EN
//   When defined, an IDX_BITS-wide global history register is XORed into
//   both the predict and update indices (gshare). When undefined, the table
//   is indexed by PC bits alone.
//
// FSM: INIT walks every table entry once after reset, writing INIT_STATE;
// RUN serves predictions and updates. o_ready mirrors the FSM state
// (0 = INIT, 1 = RUN), so the state is observable at the port.
//
// Update handshake: i_upd_valid is a single-cycle qualifier with no
// back-pressure. An update is accepted at a clock edge only when the FSM is
// in RUN and i_rst is low; updates presented in INIT are dropped with no
// side effects.

module branch_predictor #(
    parameter int         IDX_BITS   = 6,
    parameter int         DATA_WIDTH = 32,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_pc,
    output logic                  o_pred_take,
    output logic                  o_ready,
    input  logic                  i_upd_valid,
    input  logic [DATA_WIDTH-1:0] i_upd_pc,
    input  logic                  i_upd_take,
    input  logic                  i_upd_pred,
    output logic                  o_mispredict,
    output logic [DATA_WIDTH-1:0] o_br_count,
    output logic [DATA_WIDTH-1:0] o_miss_count
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                r_state;
    logic [IDX_BITS-1:0]   r_ptr;
    logic [1:0]            r_table [DEPTH];
    logic                  r_mispredict;
    logic [DATA_WIDTH-1:0] r_br_count;
    logic [DATA_WIDTH-1:0] r_miss_count;

    logic [IDX_BITS-1:0]   w_pred_idx;
    logic [IDX_BITS-1:0]   w_upd_idx;
    logic                  w_upd_accept;
    logic [1:0]            w_upd_old;
    logic [1:0]            w_upd_new;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_BITS-1:0]   r_ghr;

    // Global history: shift in each accepted outcome; frozen during INIT.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ghr <= '0;
        end else if (w_upd_accept) begin
            r_ghr <= {r_ghr[IDX_BITS-2:0], i_upd_take};
        end
    end

    // Both indices use the history value before this cycle's shift.
    always_comb begin
        w_pred_idx = i_pc[IDX_BITS+1:2] ^ r_ghr;
        w_upd_idx  = i_upd_pc[IDX_BITS+1:2] ^ r_ghr;
    end
`else
    // Plain bimodal indexing on PC word bits.
    always_comb begin
        w_pred_idx = i_pc[IDX_BITS+1:2];
        w_upd_idx  = i_upd_pc[IDX_BITS+1:2];
    end
`endif

    // Saturating increment/decrement of the addressed counter.
    always_comb begin
        w_upd_accept = i_upd_valid && (r_state == S_RUN);
        w_upd_old    = r_table[w_upd_idx];
        w_upd_new    = w_upd_old;
        if (i_upd_take) begin
            if (w_upd_old != 2'b11) begin
                w_upd_new = w_upd_old + 2'b01;
            end
        end else begin
            if (w_upd_old != 2'b00) begin
                w_upd_new = w_upd_old - 2'b01;
            end
        end
    end

    // Control FSM and statistics: INIT sweep, then accept updates in RUN.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_INIT;
            r_ptr        <= '0;
            r_mispredict <= 1'b0;
            r_br_count   <= '0;
            r_miss_count <= '0;
        end else begin
            r_mispredict <= 1'b0;
            case (r_state)
                S_INIT: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (r_ptr == IDX_BITS'(DEPTH - 1)) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_upd_accept) begin
                        if (r_br_count != '1) begin
                            r_br_count <= r_br_count + 1'b1;
                        end
                        if (i_upd_take != i_upd_pred) begin
                            r_mispredict <= 1'b1;
                            if (r_miss_count != '1) begin
                                r_miss_count <= r_miss_count + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // Counter table: INIT fills entries in order; RUN applies one update per edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == S_INIT) begin
                r_table[r_ptr] <= INIT_STATE;
            end else if (w_upd_accept) begin
                r_table[w_upd_idx] <= w_upd_new;
            end
        end
    end

    // Prediction reads the pre-update table value; forced low until ready.
    always_comb begin
        o_pred_take = (r_state == S_RUN) ? r_table[w_pred_idx][1] : 1'b0;
    end

    assign o_ready      = (r_state == S_RUN);
    assign o_mispredict = r_mispredict;
    assign o_br_count   = r_br_count;
    assign o_miss_count = r_miss_count;

endmodule
